// File: rtl/afifo_burst_drain.sv
// ---------------------------------------------------------------------------
// afifo_burst_drain
//
// Purpose:
//   Drains the read port of an async FIFO chain in fixed-length bursts of
//   BurstLen words onto a valid/ready stream with a last marker. A burst is
//   started by the chain's (already synchronised) read threshold. A flush
//   request forces out any trailing partial data, padding the final burst to
//   BurstLen words with PadWord once the chain has been dry for PadDelay
//   cycles.
//
// Ports:
//   clk            in   clock (same as the chain read clock)
//   rst            in   asynchronous active-high reset
//   fifo_r_trigger out  pop strobe to the chain (combinational)
//   fifo_r_data    in   chain read data, valid while fifo_r_ready=1
//   fifo_r_ready   in   chain holds at least one word
//   fifo_r_thresh  in   chain fill >= read threshold
//   flush          in   single-cycle request to drain the remainder
//   flush_done     out  single-cycle pulse when a flush has completed
//   out_valid      out  output word valid (registered)
//   out_data       out  output word (registered)
//   out_last       out  final word of a burst (registered)
//   out_ready      in   sink accepts the word when out_valid & out_ready
//   busy           out  a burst is in progress or a word is pending
// ---------------------------------------------------------------------------
module afifo_burst_drain #(
  parameter int           W        = 16,
  parameter int           BurstLen = 256,
  parameter logic [W-1:0] PadWord  = '0,
  parameter int           PadDelay = 8
) (
  input  logic         clk,
  input  logic         rst,
  output logic         fifo_r_trigger,
  input  logic [W-1:0] fifo_r_data,
  input  logic         fifo_r_ready,
  input  logic         fifo_r_thresh,
  input  logic         flush,
  output logic         flush_done,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         busy
);

  localparam int RemW = $clog2(BurstLen + 1);
  localparam int DryW = $clog2(PadDelay + 1);
  localparam logic [RemW-1:0] RemFull = RemW'(BurstLen);
  localparam logic [RemW-1:0] RemOne  = RemW'(1);
  localparam logic [DryW-1:0] DryMax  = DryW'(PadDelay);
  localparam logic [DryW-1:0] DryOne  = DryW'(1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

  state_t          r_state;
  logic [RemW-1:0] r_remain;
  logic [DryW-1:0] r_dry_cnt;
  logic            r_flush_pend;
  logic            r_padded;
  logic            r_flush_done;
  logic            r_out_valid;
  logic [W-1:0]    r_out_data;
  logic            r_out_last;

  logic w_dry;
  logic w_load_ok;
  logic w_slot;
  logic w_pop;
  logic w_pad;
  logic w_load;
  logic w_burst_end;
  logic w_idle_flush;
  logic w_clear_pend;

  // Chain has been empty long enough that no in-flight word can still arrive.
  assign w_dry     = (r_dry_cnt == DryMax);
  // Single output register: it may be refilled in the same cycle it drains.
  assign w_load_ok = !r_out_valid || out_ready;
  // A burst word may be produced this cycle.
  assign w_slot    = (r_state == S_BURST) && w_load_ok && (r_remain != '0);
  // Once a burst has started padding it never pops again, so late chain
  // words are kept for the next burst.
  assign w_pop     = w_slot && !r_padded && fifo_r_ready;
  assign w_pad     = w_slot && (r_padded || (!fifo_r_ready && r_flush_pend && w_dry));
  assign w_load    = w_pop || w_pad;

  assign w_burst_end  = (r_state == S_BURST) && r_out_valid && out_ready && r_out_last;
  // Flush with nothing left to send: complete without emitting an empty burst.
  assign w_idle_flush = (r_state == S_IDLE) && !fifo_r_thresh && r_flush_pend &&
                        !fifo_r_ready && w_dry;
  assign w_clear_pend = w_idle_flush || (w_burst_end && r_padded);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_remain     <= '0;
      r_dry_cnt    <= '0;
      r_flush_pend <= 1'b0;
      r_padded     <= 1'b0;
      r_flush_done <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_last   <= 1'b0;
    end else begin
      if (fifo_r_ready) begin
        r_dry_cnt <= '0;
      end else if (!w_dry) begin
        r_dry_cnt <= r_dry_cnt + DryOne;
      end

      // A new request wins over a completion in the same cycle.
      if (flush) begin
        r_flush_pend <= 1'b1;
      end else if (w_clear_pend) begin
        r_flush_pend <= 1'b0;
      end
      r_flush_done <= w_clear_pend;

      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pad ? PadWord : fifo_r_data;
        r_out_last  <= (r_remain == RemOne);
        r_remain    <= r_remain - RemOne;
        if (w_pad) begin
          r_padded <= 1'b1;
        end
      end else if (w_load_ok) begin
        // Current word (if any) was taken and nothing replaces it.
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (fifo_r_thresh || (r_flush_pend && fifo_r_ready)) begin
            r_state  <= S_BURST;
            r_remain <= RemFull;
            r_padded <= 1'b0;
          end
        end
        S_BURST: begin
          if (w_burst_end) begin
            r_state  <= S_IDLE;
            r_padded <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign fifo_r_trigger = w_pop;
  assign flush_done     = r_flush_done;
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_last       = r_out_last;
  assign busy           = (r_state != S_IDLE) || r_out_valid;

endmodule
